// File: rtl/vga_pkg.sv
// vga_pkg: constants and types shared by the VGA generator and capture blocks
package vga_pkg;
  localparam int CW = 10;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;
  localparam int PIX_W = 12;
  localparam int LINE_W = 11;
  typedef enum logic {WAIT_VSYNC, IN_FRAME} cap_state_t;
endpackage

// File: rtl/vga_sync_edge.sv
// vga_sync_edge: registers a sync input, normalises polarity and flags the assertion edge
module vga_sync_edge import vga_pkg::*; #(
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sync,
  output logic o_level,
  output logic o_edge
);
  logic r_level, r_prev;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_level <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_level <= (i_sync == SYNC_POL);
      r_prev  <= r_level;
    end
  end
  assign o_level = r_level;
  assign o_edge  = r_level & ~r_prev;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: measures line/frame geometry and colour checksum of a VGA stream, flags timing errors
module vga_capture import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int CW = vga_pkg::CW,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic [CW-1:0]     red,
  input  logic [CW-1:0]     green,
  input  logic [CW-1:0]     blue,
  input  logic              pxlen,
  input  logic              active,
  input  logic              clear_err,
  output logic              frame_valid,
  output logic [PIX_W-1:0]  line_pixels,
  output logic [LINE_W-1:0] frame_lines,
  output logic [15:0]       frame_count,
  output logic [31:0]       frame_sum,
  output logic              err_hpix,
  output logic              err_vlines,
  output logic              err_sync
);
  logic w_hs_lvl, w_hs_edge, w_vs_lvl, w_vs_edge;
  logic [CW-1:0] r_red, r_green, r_blue;
  logic r_pxlen, r_active, r_clear_err;
  cap_state_t r_state, w_state_nxt;
  logic [PIX_W-1:0] r_pix_cnt, w_pix_inc, r_line_pixels;
  logic [LINE_W-1:0] r_line_cnt, w_lines_inc, r_frame_lines;
  logic [31:0] r_sum_acc, w_sum_inc, r_frame_sum;
  logic [15:0] r_frame_count;
  logic r_frame_valid, r_err_hpix, r_err_vlines, r_err_sync;
  logic w_acc, w_in_frame, w_line_close, w_frame_close;
  logic w_hpix_set, w_vlines_set, w_sync_set;
  logic [CW+1:0] w_rgb;

  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_hs (
    .i_clk(clock), .i_rst(reset), .i_sync(hsync), .o_level(w_hs_lvl), .o_edge(w_hs_edge)
  );
  vga_sync_edge #(.SYNC_POL(SYNC_POL)) u_vs (
    .i_clk(clock), .i_rst(reset), .i_sync(vsync), .o_level(w_vs_lvl), .o_edge(w_vs_edge)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_pxlen     <= 1'b0;
      r_active    <= 1'b0;
      r_clear_err <= 1'b0;
      r_state     <= WAIT_VSYNC;
    end else begin
      r_red       <= red;
      r_green     <= green;
      r_blue      <= blue;
      r_pxlen     <= pxlen;
      r_active    <= active;
      r_clear_err <= clear_err;
      r_state     <= w_state_nxt;
    end
  end

  // A pixel sampled with a closing edge is folded into the line/frame it closes
  always_comb begin
    w_acc         = r_pxlen & r_active;
    w_in_frame    = r_state == IN_FRAME;
    w_rgb         = (CW+2)'(r_red) + (CW+2)'(r_green) + (CW+2)'(r_blue);
    w_pix_inc     = r_pix_cnt + PIX_W'(w_acc && (r_pix_cnt != '1));
    w_line_close  = w_in_frame && w_hs_edge && (w_pix_inc != '0);
    w_lines_inc   = r_line_cnt + LINE_W'(w_line_close && (r_line_cnt != '1));
    w_sum_inc     = r_sum_acc + (w_acc ? 32'(w_rgb) : 32'd0);
    w_frame_close = w_in_frame && w_vs_edge;
    w_hpix_set    = w_line_close && (w_pix_inc != PIX_W'(H_ACTIVE));
    w_vlines_set  = w_frame_close && (w_lines_inc != LINE_W'(V_ACTIVE));
    w_sync_set    = w_in_frame && w_acc && (w_hs_lvl || w_vs_lvl);
    w_state_nxt   = w_vs_edge ? IN_FRAME : r_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pix_cnt     <= '0;
      r_line_cnt    <= '0;
      r_sum_acc     <= '0;
      r_line_pixels <= '0;
      r_frame_lines <= '0;
      r_frame_sum   <= '0;
      r_frame_count <= '0;
      r_frame_valid <= 1'b0;
      r_err_hpix    <= 1'b0;
      r_err_vlines  <= 1'b0;
      r_err_sync    <= 1'b0;
    end else begin
      r_frame_valid <= w_frame_close;
      r_err_hpix    <= w_hpix_set | (r_err_hpix & ~r_clear_err);
      r_err_vlines  <= w_vlines_set | (r_err_vlines & ~r_clear_err);
      r_err_sync    <= w_sync_set | (r_err_sync & ~r_clear_err);
      if (w_line_close) r_line_pixels <= w_pix_inc;
      if (w_frame_close) begin
        r_frame_lines <= w_lines_inc;
        r_frame_sum   <= w_sum_inc;
        r_frame_count <= r_frame_count + 16'd1;
      end
      r_pix_cnt  <= (!w_in_frame || w_hs_edge || w_vs_edge) ? '0 : w_pix_inc;
      r_line_cnt <= (!w_in_frame || w_vs_edge) ? '0 : w_lines_inc;
      r_sum_acc  <= (!w_in_frame || w_vs_edge) ? '0 : w_sum_inc;
    end
  end

  assign frame_valid = r_frame_valid;
  assign line_pixels = r_line_pixels;
  assign frame_lines = r_frame_lines;
  assign frame_count = r_frame_count;
  assign frame_sum   = r_frame_sum;
  assign err_hpix    = r_err_hpix;
  assign err_vlines  = r_err_vlines;
  assign err_sync    = r_err_sync;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed stimulus with a frame scoreboard for vga_capture
module tb_vga_capture;
  logic clock = 1'b0;
  logic reset, hsync, vsync, pxlen, active, clear_err;
  logic [9:0] red, green, blue;
  logic frame_valid, err_hpix, err_vlines, err_sync;
  logic [11:0] line_pixels;
  logic [10:0] frame_lines;
  logic [15:0] frame_count;
  logic [31:0] frame_sum;

  typedef struct packed {
    logic [10:0] lines;
    logic [31:0] sum;
    logic [15:0] count;
  } frame_t;

  frame_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int nv0;
  logic m_in_frame;
  int m_lines, m_pix;
  logic [31:0] m_sum;
  logic [15:0] m_count;

  vga_capture #(.H_ACTIVE(8), .V_ACTIVE(4), .CW(10), .SYNC_POL(1'b0)) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .pxlen(pxlen), .active(active),
    .clear_err(clear_err), .frame_valid(frame_valid), .line_pixels(line_pixels),
    .frame_lines(frame_lines), .frame_count(frame_count), .frame_sum(frame_sum),
    .err_hpix(err_hpix), .err_vlines(err_vlines), .err_sync(err_sync)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drv(input logic hs, input logic vs, input logic en, input logic [9:0] c);
    hsync = hs; vsync = vs; pxlen = en; active = en;
    red = c; green = c; blue = c;
    @(negedge clock);
  endtask

  task automatic push_frame();
    frame_t e;
    if (m_in_frame) begin
      m_count++;
      e.lines = 11'(m_lines);
      e.sum = m_sum;
      e.count = m_count;
      q.push_back(e);
    end
    m_in_frame = 1'b1; m_lines = 0; m_pix = 0; m_sum = 0;
  endtask

  task automatic vpulse();
    push_frame();
    drv(1, 0, 0, 0); drv(1, 0, 0, 0); drv(1, 1, 0, 0); drv(1, 1, 0, 0);
  endtask

  // sync_last drives the final pixel together with the hsync assertion
  task automatic line(input int npix, input logic [9:0] c, input bit sync_last);
    for (int i = 0; i < npix; i++) begin
      drv((sync_last && i == npix - 1) ? 1'b0 : 1'b1, 1, 1, c);
      m_pix++;
      m_sum = m_sum + 32'(3 * c);
    end
    if (m_pix != 0) m_lines++;
    m_pix = 0;
    if (!sync_last) drv(1, 1, 0, 0);
    drv(0, 1, 0, 0); drv(0, 1, 0, 0); drv(1, 1, 0, 0); drv(1, 1, 0, 0);
  endtask

  task automatic line_vframe(input int npix, input logic [9:0] c);
    for (int i = 0; i < npix; i++) begin
      drv(1, 1, 1, c);
      m_pix++;
      m_sum = m_sum + 32'(3 * c);
    end
    drv(1, 1, 0, 0);
    if (m_pix != 0) m_lines++;
    m_pix = 0;
    push_frame();
    drv(0, 0, 0, 0); drv(0, 0, 0, 0); drv(1, 1, 0, 0); drv(1, 1, 0, 0);
  endtask

  task automatic lines(input int nl, input logic [9:0] c);
    for (int i = 0; i < nl; i++) line(8, c, 1'b0);
  endtask

  task automatic clr();
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    tick(3);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, frame_valid, 0);
    chk({tag, "_line_pixels"}, line_pixels, 0);
    chk({tag, "_frame_lines"}, frame_lines, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_frame_sum"}, frame_sum, 0);
    chk({tag, "_err_hpix"}, err_hpix, 0);
    chk({tag, "_err_vlines"}, err_vlines, 0);
    chk({tag, "_err_sync"}, err_sync, 0);
  endtask

  always @(negedge clock) begin
    if (frame_valid === 1'b1) begin
      frame_t e;
      n_valid++;
      n_vec++;
      assert (q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_frame_valid: observed 1 expected 0");
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_frame_lines", frame_lines, e.lines);
        chk("sb_frame_sum", frame_sum, e.sum);
        chk("sb_frame_count", frame_count, e.count);
      end
    end
  end

  initial begin
    reset = 1'b1; clear_err = 1'b0;
    hsync = 1'b1; vsync = 1'b1; pxlen = 1'b0; active = 1'b0;
    red = '0; green = '0; blue = '0;
    m_in_frame = 1'b0; m_lines = 0; m_pix = 0; m_sum = '0; m_count = '0;
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_zero("reset");

    vpulse(); lines(4, 1); vpulse(); tick(2);
    chk("clean_valid_count", n_valid, 1);
    chk("clean_line_pixels", line_pixels, 8);
    chk("clean_frame_sum", frame_sum, 96);
    chk("clean_frame_count", frame_count, 1);
    chk("clean_err_hpix", err_hpix, 0);
    chk("clean_err_vlines", err_vlines, 0);
    chk("clean_err_sync", err_sync, 0);

    lines(2, 1); line(7, 1, 1'b0);
    chk("short_line_pixels", line_pixels, 7);
    chk("short_err_hpix", err_hpix, 1);
    line(8, 1, 1'b0);
    chk("short_err_hpix_sticky", err_hpix, 1);
    vpulse(); clr();
    chk("short_err_hpix_cleared", err_hpix, 0);
    chk("short_err_vlines", err_vlines, 0);

    lines(5, 1); vpulse(); tick(2);
    chk("long_frame_lines", frame_lines, 5);
    chk("long_err_vlines", err_vlines, 1);
    lines(4, 1); vpulse(); tick(2);
    chk("after_long_frame_lines", frame_lines, 4);
    chk("after_long_err_vlines", err_vlines, 1);
    clr();
    chk("vlines_cleared", err_vlines, 0);

    lines(4, 10'd1023); vpulse(); tick(2);
    chk("max_colour_sum", frame_sum, 98208);
    force dut.r_sum_acc = 32'hFFFF_FC18;
    tick(1);
    release dut.r_sum_acc;
    m_sum = 32'hFFFF_FC18;
    lines(4, 10'd1023); vpulse(); tick(2);
    chk("wrap_sum", frame_sum, 97208);

    line(8, 1, 1'b1);
    chk("sync_pix_line_pixels", line_pixels, 8);
    chk("sync_pix_err_sync", err_sync, 1);
    chk("sync_pix_err_hpix", err_hpix, 0);
    lines(3, 1); vpulse(); clr();
    chk("sync_err_cleared", err_sync, 0);

    lines(3, 1); line_vframe(8, 1); tick(2);
    chk("same_edge_frame_lines", frame_lines, 4);
    chk("same_edge_err_vlines", err_vlines, 0);

    lines(2, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk_zero("midreset");
    m_in_frame = 1'b0; m_lines = 0; m_pix = 0; m_sum = '0; m_count = '0;
    nv0 = n_valid;
    vpulse(); tick(3);
    chk("midreset_first_vsync_silent", n_valid, nv0);
    lines(4, 1); vpulse(); tick(2);
    chk("midreset_second_vsync_valid", n_valid, nv0 + 1);
    chk("midreset_frame_count", frame_count, 1);

    tick(6);
    chk("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
